// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one UART byte transmitter among NUM_REQ byte-stream requesters.
//   Grants rotate round-robin at packet granularity (a packet ends on the
//   byte carrying req_last). An optional header byte {HDR_MAGIC, grant_id}
//   can be sent ahead of each packet so the far end can demultiplex. While
//   the far-end receive FIFO reports full, no grant is made and no byte is
//   offered.
//
// Ports
//   tx_clk_in        clock
//   rst              synchronous, active-high reset
//   req_valid/data/last/ready   per-requester byte streams (lane i = data[8i+:8])
//   hdr_en           emit a header byte before each packet (sampled at grant)
//   rx_fifo_full_in  far-end receive FIFO full
//   tx_valid/tx_data/tx_ready   byte handshake toward the serializer
//   grant_id         current or most recent granted requester
//   busy             a packet (header or data) is in progress
//   timeout_err      one-cycle pulse when a stalled grant is revoked
module uart_tx_arbiter #(
  parameter int         NUM_REQ   = 4,
  parameter logic [3:0] HDR_MAGIC = 4'hA,
  parameter int         TIMEOUT   = 1024,
  parameter int         CNT_W     = 16
) (
  input  logic                 tx_clk_in,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic                 hdr_en,
  input  logic                 rx_fifo_full_in,
  output logic                 tx_valid,
  output logic [7:0]           tx_data,
  input  logic                 tx_ready,
  output logic [3:0]           grant_id,
  output logic                 busy,
  output logic                 timeout_err
);

  typedef enum logic [1:0] {ST_IDLE, ST_HDR, ST_DATA} state_t;

  state_t           state_q, state_d;
  logic [3:0]       grant_q, grant_d;
  logic [3:0]       last_g_q, last_g_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             tout_q, tout_d;

  logic             g_valid, g_last;
  logic [7:0]       g_data;
  logic             pick_found;
  logic [3:0]       pick_idx;
  logic             tx_fire;

  // Lane of the currently granted requester.
  always_comb begin
    g_valid = 1'b0;
    g_last  = 1'b0;
    g_data  = 8'h00;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q == 4'(i)) begin
        g_valid = req_valid[i];
        g_last  = req_last[i];
        g_data  = req_data[8*i +: 8];
      end
    end
  end

  // Round-robin search starting just above last_g: first try indices above
  // the pointer, then wrap to the lowest valid index.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = 4'h0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!pick_found && req_valid[i] && (4'(i) > last_g_q)) begin
        pick_found = 1'b1;
        pick_idx   = 4'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!pick_found && req_valid[i]) begin
        pick_found = 1'b1;
        pick_idx   = 4'(i);
      end
    end
  end

  // Byte handshake is combinational so backpressure takes effect in the
  // same cycle it is raised.
  always_comb begin
    tx_valid  = 1'b0;
    tx_data   = 8'h00;
    req_ready = '0;
    case (state_q)
      ST_HDR: begin
        tx_valid = !rx_fifo_full_in;
        tx_data  = {HDR_MAGIC, grant_q};
      end
      ST_DATA: begin
        tx_valid = g_valid && !rx_fifo_full_in;
        tx_data  = g_data;
        for (int i = 0; i < NUM_REQ; i++) begin
          if (grant_q == 4'(i)) req_ready[i] = tx_ready && !rx_fifo_full_in;
        end
      end
      default: ;
    endcase
  end

  assign tx_fire = tx_valid && tx_ready;

  // Next-state logic. The starvation counter only advances while the
  // granted requester has nothing to send and the far end could take it;
  // a transfer always clears it, so a transfer beats the threshold.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    last_g_d = last_g_q;
    cnt_d    = cnt_q;
    tout_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (pick_found && !rx_fifo_full_in) begin
          grant_d = pick_idx;
          state_d = hdr_en ? ST_HDR : ST_DATA;
        end
      end
      ST_HDR: begin
        cnt_d = '0;
        if (tx_fire) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (tx_fire) begin
          cnt_d = '0;
          if (g_last) begin
            last_g_d = grant_q;
            state_d  = ST_IDLE;
          end
        end else if (!g_valid && !rx_fifo_full_in) begin
          if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            tout_d   = 1'b1;
            last_g_d = grant_q;
            cnt_d    = '0;
            state_d  = ST_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State registers; the pointer resets to the top index so requester 0
  // wins the first arbitration.
  always_ff @(posedge tx_clk_in) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      grant_q  <= 4'h0;
      last_g_q <= 4'(NUM_REQ - 1);
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      tout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      last_g_q <= last_g_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      tout_q   <= tout_d;
    end
  end

  assign grant_id    = grant_q;
  assign busy        = busy_q;
  assign timeout_err = tout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
//   Self-checking bench for uart_tx_arbiter (NUM_REQ=4, TIMEOUT=16).
//   Random traffic is checked against a packet-level reference model that
//   keeps per-requester packet queues and derives the expected serializer
//   byte stream from round-robin order; directed sequences cover the
//   single-requester header case, starvation timeout and reset mid-packet.
module tb_uart_tx_arbiter;

  localparam int N = 4;

  logic          tx_clk_in;
  logic          rst;
  logic [N-1:0]  req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]  req_last;
  logic [N-1:0]  req_ready;
  logic          hdr_en;
  logic          rx_fifo_full_in;
  logic          tx_valid;
  logic [7:0]    tx_data;
  logic          tx_ready;
  logic [3:0]    grant_id;
  logic          busy;
  logic          timeout_err;

  int n_checks = 0;
  int n_fail   = 0;

  // Producer packet storage: {last, byte} per entry, head/tail per requester.
  logic [8:0] pmem [N][64];
  int         phead [N];
  int         ptail [N];
  logic [8:0] exp_q [$];

  uart_tx_arbiter #(
    .NUM_REQ(N), .HDR_MAGIC(4'hA), .TIMEOUT(16), .CNT_W(16)
  ) dut (
    .tx_clk_in(tx_clk_in), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .hdr_en(hdr_en), .rx_fifo_full_in(rx_fifo_full_in),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
  );

  initial tx_clk_in = 1'b0;
  always #5 tx_clk_in = ~tx_clk_in;

  // Compare one observed value with its expected value.
  task checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Drive one cycle of inputs at the falling edge and settle before sampling.
  task applyStimulus(input logic [N-1:0] v, input logic [N-1:0] l,
                     input logic [31:0] d, input logic rdy, input logic fl);
    @(negedge tx_clk_in);
    req_valid       = v;
    req_last        = l;
    req_data        = d;
    tx_ready        = rdy;
    rx_fifo_full_in = fl;
    #2;
  endtask

  // Synchronous reset with idle inputs, then check the reset values.
  task doReset();
    @(negedge tx_clk_in);
    rst = 1'b1;
    req_valid = '0; req_last = '0; req_data = '0;
    tx_ready = 1'b0; rx_fifo_full_in = 1'b0;
    repeat (2) @(negedge tx_clk_in);
    rst = 1'b0;
    #2;
    checkOutput("rst_tx_valid", 32'(tx_valid), 0);
    checkOutput("rst_tx_data", 32'(tx_data), 0);
    checkOutput("rst_req_ready", 32'(req_ready), 0);
    checkOutput("rst_grant_id", 32'(grant_id), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_timeout", 32'(timeout_err), 0);
  endtask

  // Random traffic: every requester starts with npkt queued packets. A
  // requester waiting for a grant keeps valid high; the granted one may
  // insert short gaps (at most 3 cycles, well under the timeout).
  task runRandom(input logic hdr_mode, input int npkt);
    int last_served, cur_g, cyc, len, gap, g;
    logic in_pkt, after_last, fire, done;
    logic [N-1:0] v, l, exp_mask;
    logic [31:0] d;
    logic [8:0] e;
    hdr_en = hdr_mode;
    doReset();
    for (int i = 0; i < N; i++) begin
      phead[i] = 0;
      ptail[i] = 0;
      for (int p = 0; p < npkt; p++) begin
        len = $urandom_range(1, 4);
        for (int b = 0; b < len; b++) begin
          pmem[i][ptail[i]] = {(b == len - 1), 8'($urandom)};
          ptail[i]++;
        end
      end
    end
    exp_q.delete();
    last_served = N - 1;
    cur_g = 0;
    in_pkt = 1'b0;
    after_last = 1'b0;
    gap = 0;
    cyc = 0;
    done = 1'b0;
    while (!done && cyc < 3000) begin
      v = '0; l = '0; d = '0;
      for (int i = 0; i < N; i++) begin
        if (phead[i] < ptail[i]) begin
          d[8*i +: 8] = pmem[i][phead[i]][7:0];
          l[i]        = pmem[i][phead[i]][8];
          if (in_pkt && i == cur_g) begin
            if (gap >= 3 || $urandom_range(0, 2) != 0) begin
              v[i] = 1'b1;
              gap  = 0;
            end else begin
              gap++;
            end
          end else begin
            v[i] = 1'b1;
          end
        end
      end
      applyStimulus(v, l, d, ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0));
      fire = tx_valid && tx_ready;
      exp_mask = '0;
      if (rx_fifo_full_in) begin
        checkOutput("full_tx_valid", 32'(tx_valid), 0);
        checkOutput("full_req_ready", 32'(req_ready), 0);
      end
      checkOutput("rand_timeout", 32'(timeout_err), 0);
      if (after_last) begin
        checkOutput("gap_busy", 32'(busy), 0);
        checkOutput("gap_tx_valid", 32'(tx_valid), 0);
        after_last = 1'b0;
      end
      if (fire && !in_pkt) begin
        g = -1;
        for (int k = 1; k <= N; k++) begin
          if (g < 0 && phead[(last_served + k) % N] < ptail[(last_served + k) % N])
            g = (last_served + k) % N;
        end
        if (g < 0) begin
          checkOutput("rand_spurious", 32'(fire), 0);
        end else begin
          cur_g  = g;
          in_pkt = 1'b1;
          gap    = 0;
          if (hdr_mode) exp_q.push_back({1'b1, 4'hA, 4'(g)});
          for (int j = phead[g]; j < ptail[g]; j++) begin
            exp_q.push_back({1'b0, pmem[g][j][7:0]});
            if (pmem[g][j][8]) break;
          end
        end
      end
      if (fire && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("rand_tx_data", 32'(tx_data), 32'(e[7:0]));
        checkOutput("rand_grant_id", 32'(grant_id), 32'(cur_g));
        if (!e[8]) exp_mask = N'(1) << cur_g;
        if (exp_q.size() == 0) begin
          in_pkt      = 1'b0;
          last_served = cur_g;
          after_last  = 1'b1;
        end
      end
      checkOutput("rand_accept", 32'(req_valid & req_ready), 32'(exp_mask));
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && req_ready[i]) phead[i]++;
      end
      cyc++;
      done = !in_pkt;
      for (int i = 0; i < N; i++) if (phead[i] < ptail[i]) done = 1'b0;
    end
    checkOutput("rand_drain", 32'(done), 1);
    applyStimulus('0, '0, '0, 1'b1, 1'b0);
    checkOutput("rand_end_tx_valid", 32'(tx_valid), 0);
  endtask

  // Single requester 1 with a header: expect A1 11 22 33.
  task runSingle();
    logic [7:0] sb [4];
    logic [7:0] db [3];
    int k, o;
    sb = '{8'hA1, 8'h11, 8'h22, 8'h33};
    db = '{8'h11, 8'h22, 8'h33};
    hdr_en = 1'b1;
    doReset();
    k = 0; o = 0;
    for (int c = 0; c < 20 && o < 4; c++) begin
      applyStimulus(4'b0010, (k == 2) ? 4'b0010 : 4'b0000, {16'h0, db[k], 8'h0}, 1'b1, 1'b0);
      if (tx_valid && tx_ready) begin
        checkOutput("single_tx_data", 32'(tx_data), 32'(sb[o]));
        checkOutput("single_grant_id", 32'(grant_id), 1);
        o++;
      end
      if (req_ready[1]) k++;
    end
    checkOutput("single_count", 32'(o), 4);
    applyStimulus('0, '0, '0, 1'b1, 1'b0);
    checkOutput("single_busy_fall", 32'(busy), 0);
    checkOutput("single_idle_tx", 32'(tx_valid), 0);
  endtask

  // Requester 2 sends one non-final byte and goes quiet. The pulse must
  // rise on the 16th clock edge after the transfer edge, i.e. on the 17th
  // sample after the transfer sample; requester 3 is served next.
  task runTimeout();
    int n;
    logic found, got;
    logic [31:0] d;
    d = {8'h77, 8'h5C, 16'h0};
    hdr_en = 1'b0;
    doReset();
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      applyStimulus(4'b1100, 4'b1000, d, 1'b1, 1'b0);
      if (tx_valid && tx_ready) begin
        checkOutput("to_first_data", 32'(tx_data), 32'h5C);
        checkOutput("to_first_grant", 32'(grant_id), 2);
        got = 1'b1;
      end
    end
    checkOutput("to_first_seen", 32'(got), 1);
    n = 0;
    found = 1'b0;
    while (!found && n < 40) begin
      applyStimulus(4'b1000, 4'b1000, d, 1'b1, 1'b0);
      n++;
      if (timeout_err) found = 1'b1;
    end
    checkOutput("to_latency", 32'(n), 17);
    checkOutput("to_busy", 32'(busy), 0);
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      applyStimulus(4'b1000, 4'b1000, d, 1'b1, 1'b0);
      if (c == 0) checkOutput("to_pulse_width", 32'(timeout_err), 0);
      if (tx_valid && tx_ready) begin
        checkOutput("to_next_grant", 32'(grant_id), 3);
        checkOutput("to_next_data", 32'(tx_data), 32'h77);
        got = 1'b1;
      end
    end
    checkOutput("to_next_seen", 32'(got), 1);
  endtask

  // Reset during requester 2's packet (pointer at 1); afterwards requester
  // 0 must win even though 2 and 3 are still requesting.
  task runResetMid();
    int n;
    logic [31:0] d;
    d = {8'h55, 8'h33, 8'h00, 8'h11};
    hdr_en = 1'b1;
    doReset();
    n = 0;
    for (int c = 0; c < 10 && n == 0; c++) begin
      applyStimulus(4'b0010, 4'b0010, 32'h0000_4200, 1'b1, 1'b0);
      if (tx_valid && tx_ready && req_ready[1]) n = 1;
    end
    checkOutput("rm_pre_packet", 32'(n), 1);
    n = 0;
    for (int c = 0; c < 10 && n < 2; c++) begin
      applyStimulus(4'b1101, 4'b0000, d, 1'b1, 1'b0);
      if (tx_valid && tx_ready) n++;
    end
    checkOutput("rm_mid_grant", 32'(grant_id), 2);
    checkOutput("rm_mid_data", 32'(tx_data), 32'h33);
    @(negedge tx_clk_in);
    rst = 1'b1;
    @(negedge tx_clk_in);
    rst = 1'b0;
    #2;
    checkOutput("rm_tx_valid", 32'(tx_valid), 0);
    checkOutput("rm_tx_data", 32'(tx_data), 0);
    checkOutput("rm_req_ready", 32'(req_ready), 0);
    checkOutput("rm_busy", 32'(busy), 0);
    checkOutput("rm_grant_id", 32'(grant_id), 0);
    checkOutput("rm_timeout", 32'(timeout_err), 0);
    n = 0;
    for (int c = 0; c < 10 && n == 0; c++) begin
      applyStimulus(4'b1101, 4'b0000, d, 1'b1, 1'b0);
      if (tx_valid && tx_ready) begin
        checkOutput("rm_next_hdr", 32'(tx_data), 32'hA0);
        checkOutput("rm_next_grant", 32'(grant_id), 0);
        n = 1;
      end
    end
    checkOutput("rm_next_seen", 32'(n), 1);
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0; req_last = '0; req_data = '0;
    hdr_en = 1'b0; tx_ready = 1'b0; rx_fifo_full_in = 1'b0;
    runSingle();
    runRandom(1'b1, 6);
    runRandom(1'b0, 6);
    runTimeout();
    runResetMid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not complete, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
